// File: rtl/dram_bank_if.sv
// rtl/dram_bank_if.sv - request/response bundle between dmem_controller and dram_bank
//
// Purpose: groups the controller strobes and the bank responses into one bundle.
// Signals:
//   rEN     controller -> bank  read strobe, one-cycle pulse
//   wEN     controller -> bank  write strobe, one-cycle pulse
//   addr    controller -> bank  word address (WIDTH bits)
//   DR_OUT  controller -> bank  write data (WIDTH bits)
//   MEM     bank -> controller  registered read data (WIDTH bits)
//   rd_vld  bank -> controller  MEM updated on this edge
//   ready   bank -> controller  self-clear finished
//   err     bank -> controller  request dropped
// Modports: master = dmem_controller side, slave = dram_bank side.
interface dram_bank_if #(
  parameter int WIDTH = 8
);
  logic             rEN;
  logic             wEN;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] DR_OUT;
  logic [WIDTH-1:0] MEM;
  logic             rd_vld;
  logic             ready;
  logic             err;

  modport master (
    output rEN, wEN, addr, DR_OUT,
    input  MEM, rd_vld, ready, err
  );

  modport slave (
    input  rEN, wEN, addr, DR_OUT,
    output MEM, rd_vld, ready, err
  );
endinterface

// File: rtl/dram_bank.sv
// rtl/dram_bank.sv - single-port data RAM with post-reset self-clear
//
// Purpose: word-addressed RAM behind dmem_controller. After reset it zeroes
// every word (INIT, DEPTH cycles), then serves one read or write per cycle
// with registered read data. Requests it cannot perform pulse err.
// Ports:
//   Clk    in   system clock, rising edge
//   Rst_n  in   asynchronous active-low reset
//   bus    dram_bank_if.slave: rEN, wEN, addr, DR_OUT in; MEM, rd_vld, ready, err out
// Parameters: WIDTH (data/address width), DEPTH (words, 1..2**WIDTH).
// Build option: DRAM_WR_FWD_EN - when defined, a simultaneous in-range read
// and write performs both (write-first, read data forwarded from DR_OUT);
// when undefined, only the write is performed and the read is flagged.
module dram_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic       Clk,
  input  logic       Rst_n,
  dram_bank_if.slave bus
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH:0]   DEPTH_W = (WIDTH + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] init_cnt;
  logic [WIDTH-1:0] ram [DEPTH];

  logic             addr_ok;
  logic [AW-1:0]    ram_idx;
  logic             ram_we;
  logic [AW-1:0]    ram_wa;
  logic [WIDTH-1:0] ram_wd;
  logic             mem_ld;
  logic [WIDTH-1:0] mem_d;
  logic             rd_vld_d;
  logic             err_d;

  // One extra bit so DEPTH == 2**WIDTH compares correctly (every addr in range).
  assign addr_ok = ({1'b0, bus.addr} < DEPTH_W);
  assign ram_idx = bus.addr[AW-1:0];

  always_comb begin
    state_d  = state_q;
    ram_we   = 1'b0;
    ram_wa   = ram_idx;
    ram_wd   = bus.DR_OUT;
    mem_ld   = 1'b0;
    mem_d    = '0;
    rd_vld_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Self-clear owns the write port; any request is dropped.
        ram_we = 1'b1;
        ram_wa = init_cnt[AW-1:0];
        ram_wd = '0;
        err_d  = bus.rEN | bus.wEN;
        if (init_cnt == LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!addr_ok) begin
          // Out of range wins over the dual-strobe rule in both build modes.
          err_d = bus.rEN | bus.wEN;
          if (bus.rEN) begin
            mem_ld   = 1'b1;
            mem_d    = '0;
            rd_vld_d = 1'b1;
          end
        end else if (bus.rEN && bus.wEN) begin
          ram_we = 1'b1;
`ifdef DRAM_WR_FWD_EN
          mem_ld   = 1'b1;
          mem_d    = bus.DR_OUT;
          rd_vld_d = 1'b1;
`else
          err_d = 1'b1;
`endif
        end else if (bus.wEN) begin
          ram_we = 1'b1;
        end else if (bus.rEN) begin
          mem_ld   = 1'b1;
          mem_d    = ram[ram_idx];
          rd_vld_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_INIT;
      init_cnt   <= '0;
      bus.MEM    <= '0;
      bus.rd_vld <= 1'b0;
      bus.ready  <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Only meaningful during INIT; its value after INIT is never used.
      if (state_q == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
      if (mem_ld) begin
        bus.MEM <= mem_d;
      end
      bus.rd_vld <= rd_vld_d;
      bus.err    <= err_d;
      bus.ready  <= (state_d == ST_RUN);
    end
  end

  // Array has no reset; INIT is what makes its contents defined.
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      ram[ram_wa] <= ram_wd;
    end
  end

endmodule

// File: tb/tb_dram_bank.sv
// tb/tb_dram_bank.sv - randomized model-checked bench for dram_bank (DEPTH 256 and 200)
module tb_dram_bank;

  localparam int W = 8;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       r_en;
  logic       w_en;
  logic [7:0] a;
  logic [7:0] d;

  always #5 Clk = ~Clk;

  dram_bank_if #(.WIDTH(W)) if0 ();
  dram_bank_if #(.WIDTH(W)) if1 ();

  assign if0.rEN    = r_en;
  assign if0.wEN    = w_en;
  assign if0.addr   = a;
  assign if0.DR_OUT = d;
  assign if1.rEN    = r_en;
  assign if1.wEN    = w_en;
  assign if1.addr   = a;
  assign if1.DR_OUT = d;

  dram_bank #(.WIDTH(W), .DEPTH(256)) u_full (.Clk(Clk), .Rst_n(Rst_n), .bus(if0));
  dram_bank #(.WIDTH(W), .DEPTH(200)) u_part (.Clk(Clk), .Rst_n(Rst_n), .bus(if1));

  logic [7:0] q   [2];
  logic       vld [2];
  logic       rdy [2];
  logic       er  [2];

  assign q[0] = if0.MEM;  assign vld[0] = if0.rd_vld;
  assign rdy[0] = if0.ready; assign er[0] = if0.err;
  assign q[1] = if1.MEM;  assign vld[1] = if1.rd_vld;
  assign rdy[1] = if1.ready; assign er[1] = if1.err;

  // Behavioural model: contents, last read value, and cycles since reset.
  int         depth [2] = '{256, 200};
  logic [7:0] m_mem [2][256];
  logic [7:0] m_q   [2];
  logic       m_vld [2];
  logic       m_rdy [2];
  logic       m_err [2];
  int         m_cyc [2];

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_q[k] = 8'h00; m_vld[k] = 1'b0; m_rdy[k] = 1'b0;
        m_err[k] = 1'b0; m_cyc[k] = 0;
        for (int i = 0; i < 256; i++) m_mem[k][i] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_vld[k] = 1'b0;
        m_err[k] = 1'b0;
        if (m_cyc[k] < depth[k]) begin
          if (r_en || w_en) m_err[k] = 1'b1;
          m_cyc[k]++;
        end else if (int'(a) >= depth[k]) begin
          if (r_en || w_en) m_err[k] = 1'b1;
          if (r_en) begin
            m_q[k] = 8'h00;
            m_vld[k] = 1'b1;
          end
        end else if (r_en && w_en) begin
          m_mem[k][a] = d;
`ifdef DRAM_WR_FWD_EN
          m_q[k] = d;
          m_vld[k] = 1'b1;
`else
          m_err[k] = 1'b1;
`endif
        end else if (w_en) begin
          m_mem[k][a] = d;
        end else if (r_en) begin
          m_q[k] = m_mem[k][a];
          m_vld[k] = 1'b1;
        end
        m_rdy[k] = (m_cyc[k] >= depth[k]);
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input int k, input logic act, input logic exp);
    chk(name, k, {7'b0, act}, {7'b0, exp});
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge Clk) begin
    if (Rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk ("MEM",    k, q[k],   m_q[k]);
        chkb("rd_vld", k, vld[k], m_vld[k]);
        chkb("ready",  k, rdy[k], m_rdy[k]);
        chkb("err",    k, er[k],  m_err[k]);
      end
    end
  end

  task automatic cyc(input logic r, input logic w, input logic [7:0] ad, input logic [7:0] dd);
    r_en = r; w_en = w; a = ad; d = dd;
    @(negedge Clk);
  endtask

  task automatic run_init_full();
    for (int i = 1; i <= 255; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 8'h00);
    end
    chkb("full_ready_255", 0, rdy[0], 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    chkb("full_ready_256", 0, rdy[0], 1'b1);
  endtask

  initial begin
    r_en = 1'b0; w_en = 1'b0; a = 8'h00; d = 8'h00;
    repeat (3) @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      chk ("rst_MEM",    k, q[k], 8'h00);
      chkb("rst_rd_vld", k, vld[k], 1'b0);
      chkb("rst_ready",  k, rdy[k], 1'b0);
      chkb("rst_err",    k, er[k], 1'b0);
    end
    Rst_n = 1'b1;

    // INIT with a dropped read at cycle 5
    for (int i = 1; i <= 255; i++) begin
      if (i == 5) begin
        cyc(1'b1, 1'b0, 8'h33, 8'h00);
        chkb("init_read_err", 0, er[0], 1'b1);
        chkb("init_read_vld", 0, vld[0], 1'b0);
        chk ("init_read_MEM", 0, q[0], 8'h00);
      end else begin
        cyc(1'b0, 1'b0, 8'h00, 8'h00);
      end
      if (i == 199) chkb("part_ready_199", 1, rdy[1], 1'b0);
      if (i == 200) chkb("part_ready_200", 1, rdy[1], 1'b1);
    end
    chkb("full_ready_255", 0, rdy[0], 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    chkb("full_ready_256", 0, rdy[0], 1'b1);

    // Cleared contents
    cyc(1'b1, 1'b0, 8'h00, 8'h00);
    chk ("clr_rd_00", 0, q[0], 8'h00); chkb("clr_vld_00", 0, vld[0], 1'b1);
    cyc(1'b1, 1'b0, 8'h7F, 8'h00);
    chk ("clr_rd_7F", 0, q[0], 8'h00);
    cyc(1'b1, 1'b0, 8'hFF, 8'h00);
    chk ("clr_rd_FF", 0, q[0], 8'h00); chkb("clr_err_FF", 0, er[0], 1'b0);
    chkb("oor_rd_FF_err", 1, er[1], 1'b1); chkb("oor_rd_FF_vld", 1, vld[1], 1'b1);

    // Write then read, hold on idle
    cyc(1'b0, 1'b1, 8'h10, 8'hA5);
    chkb("wr_no_vld", 0, vld[0], 1'b0);
    cyc(1'b1, 1'b0, 8'h10, 8'h00);
    chk ("raw_MEM", 0, q[0], 8'hA5); chkb("raw_vld", 0, vld[0], 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    chk ("hold_MEM", 0, q[0], 8'hA5); chkb("hold_vld", 0, vld[0], 1'b0);

    // Address hit during INIT stays zero
    cyc(1'b1, 1'b0, 8'h33, 8'h00);
    chk ("init_addr_zero", 0, q[0], 8'h00);

    // Out-of-range on the 200-word bank, in range on the 256-word bank
    cyc(1'b0, 1'b1, 8'hC8, 8'h33);
    chkb("oor_wr_err", 1, er[1], 1'b1); chkb("inr_wr_err", 0, er[0], 1'b0);
    cyc(1'b1, 1'b0, 8'hC8, 8'h00);
    chk ("oor_rd_MEM", 1, q[1], 8'h00); chkb("oor_rd_vld", 1, vld[1], 1'b1);
    chkb("oor_rd_err", 1, er[1], 1'b1);
    chk ("inr_rd_MEM", 0, q[0], 8'h33); chkb("inr_rd_err", 0, er[0], 1'b0);

    // Simultaneous read and write
    cyc(1'b1, 1'b1, 8'h20, 8'h5A);
`ifdef DRAM_WR_FWD_EN
    chk ("dual_MEM", 0, q[0], 8'h5A); chkb("dual_vld", 0, vld[0], 1'b1);
    chkb("dual_err", 0, er[0], 1'b0);
`else
    chk ("dual_MEM", 0, q[0], 8'h33); chkb("dual_vld", 0, vld[0], 1'b0);
    chkb("dual_err", 0, er[0], 1'b1);
`endif
    cyc(1'b1, 1'b0, 8'h20, 8'h00);
    chk ("dual_later_rd", 0, q[0], 8'h5A); chk("dual_later_rd", 1, q[1], 8'h5A);

    // Randomized traffic, biased toward a few addresses for read-after-write
    for (int i = 0; i < 2000; i++) begin
      logic       rr, ww;
      logic [7:0] aa, dd;
      rr = ($urandom_range(0, 9) < 4);
      ww = ($urandom_range(0, 9) < 4);
      aa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      dd = 8'($urandom_range(0, 255));
      cyc(rr, ww, aa, dd);
    end

    // Reset mid-access, then mid-INIT
    cyc(1'b0, 1'b1, 8'h40, 8'h77);
    cyc(1'b1, 1'b0, 8'h40, 8'h00);
    chk ("pre_rst_MEM", 0, q[0], 8'h77);
    r_en = 1'b0; w_en = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    chk ("async_rst_MEM", 0, q[0], 8'h00);
    chkb("async_rst_vld", 0, vld[0], 1'b0);
    chkb("async_rst_ready", 0, rdy[0], 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (100) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    #2 Rst_n = 1'b0;
    #1;
    chkb("midinit_rst_ready", 0, rdy[0], 1'b0);
    chk ("midinit_rst_MEM", 0, q[0], 8'h00);
    @(negedge Clk);
    Rst_n = 1'b1;
    run_init_full();
    cyc(1'b1, 1'b0, 8'h40, 8'h00);
    chk ("post_rst_rd_40", 0, q[0], 8'h00);
    cyc(1'b1, 1'b0, 8'h10, 8'h00);
    chk ("post_rst_rd_10", 0, q[0], 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
